// File: rtl/clk_divider_multi.sv
// clk_divider_multi: multi-channel programmable clock divider.
// Each channel counts clk_MHz cycles against a run-time writable half-period D
// and produces a 50%-duty divided clock plus a one-cycle tick on every counter
// wrap. New D values are held pending and applied only at a period boundary,
// so the divided clock never glitches. Disabling a channel whose clock is high
// lets the high phase finish before the channel goes idle.
//
// Ports:
//   clk_MHz      in   system clock, rising edge
//   reset        in   asynchronous, active-high
//   ch_en        in   per-channel run enable
//   sync_all     in   one-cycle pulse: restart all running channels in phase
//   div_wr_en    in   divide-value write strobe
//   div_wr_ch    in   target channel of the write
//   div_wr_val   in   new half-period D in clk_MHz cycles
//   clk_out      out  divided clocks, period 2*D
//   tick         out  one-cycle pulse per counter wrap
//   div_pending  out  new D accepted but not yet applied
//   wr_err       out  sticky flag: illegal write (D==0 or channel out of range)
module clk_divider_multi #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned DEFAULT_DIV = 250000
) (
  input  logic                       clk_MHz,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          ch_en,
  input  logic                       sync_all,
  input  logic                       div_wr_en,
  input  logic [$clog2(NUM_CH):0]    div_wr_ch,
  input  logic [CNT_W-1:0]           div_wr_val,
  output logic [NUM_CH-1:0]          clk_out,
  output logic [NUM_CH-1:0]          tick,
  output logic [NUM_CH-1:0]          div_pending,
  output logic                       wr_err
);

  localparam int unsigned    CH_W     = $clog2(NUM_CH) + 1;
  localparam logic [CH_W-1:0] NUM_CH_W = CH_W'(NUM_CH);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStop
  } ch_state_e;

  logic wr_legal;
  logic wr_ok;

  assign wr_legal = (div_wr_val != '0) && (div_wr_ch < NUM_CH_W);
  assign wr_ok    = div_wr_en && wr_legal;

  always_ff @(posedge clk_MHz or posedge reset) begin
    if (reset) begin
      wr_err <= 1'b0;
    end else if (div_wr_en && !wr_legal) begin
      wr_err <= 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_state_e        st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wr_hit;
    logic             wrap;
    logic             apply;

    assign wr_hit = wr_ok && (div_wr_ch == CH_W'(g));
    assign wrap   = (cnt_q == (div_q - CNT_W'(1)));

    always_comb begin
      st_d       = st_q;
      cnt_d      = cnt_q;
      clk_d      = clk_q;
      tick_d     = 1'b0;
      div_d      = div_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      apply      = 1'b0;

      unique case (st_q)
        StIdle: begin
          cnt_d = '0;
          clk_d = 1'b0;
          // No period in flight, so a pending value can take effect at once.
          apply = pend_vld_q;
          if (ch_en[g]) begin
            st_d = StRun;
          end
        end
        StRun, StStop: begin
          if (sync_all) begin
            // Sync wins over a coincident wrap.
            cnt_d = '0;
            clk_d = 1'b0;
            apply = pend_vld_q;
            if (st_q == StStop) begin
              st_d = StIdle;
            end
          end else if ((st_q == StRun) && !ch_en[g] && !clk_q) begin
            // Clock already low: stopping here cannot cut a high phase short.
            st_d  = StIdle;
            cnt_d = '0;
          end else begin
            if (wrap) begin
              cnt_d  = '0;
              clk_d  = ~clk_q;
              tick_d = 1'b1;
              apply  = pend_vld_q;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
            // Disabled with clock high: finish the high phase, then idle.
            if (ch_en[g]) begin
              st_d = StRun;
            end else begin
              st_d = wrap ? StIdle : StStop;
            end
          end
        end
        default: begin
          st_d = StIdle;
        end
      endcase

      if (apply) begin
        div_d      = pend_q;
        pend_vld_d = 1'b0;
      end
      // A write landing in the applying cycle stays pending for the next boundary.
      if (wr_hit) begin
        pend_d     = div_wr_val;
        pend_vld_d = 1'b1;
      end
    end

    always_ff @(posedge clk_MHz or posedge reset) begin
      if (reset) begin
        st_q       <= StIdle;
        cnt_q      <= '0;
        div_q      <= CNT_W'(DEFAULT_DIV);
        pend_q     <= '0;
        pend_vld_q <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        st_q       <= st_d;
        cnt_q      <= cnt_d;
        div_q      <= div_d;
        pend_q     <= pend_d;
        pend_vld_q <= pend_vld_d;
        clk_q      <= clk_d;
        tick_q     <= tick_d;
      end
    end

    assign clk_out[g]     = clk_q;
    assign tick[g]        = tick_q;
    assign div_pending[g] = pend_vld_q;
  end

endmodule
